// File: rtl/wb_queue.sv
// wb_queue: writeback-side write queue in front of an 8x8 register file.
//
// Collects write requests from the ALU and the load path into a small
// in-order queue. The queue drains one entry per cycle into a registered
// write port (regwrite/wa/wd). Values that are still pending are forwarded
// to the two register file read ports.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   alu_valid/alu_wa/alu_wd        ALU write request
//   alu_ready                      ALU request accepted when valid && ready
//   mem_valid/mem_wa/mem_wd        load write request
//   mem_ready                      load request accepted when valid && ready
//   regwrite/wa/wd                 registered register file write port
//   ra1/ra2, rf_rd1/rf_rd2         register file read addresses and raw data
//   fwd_rd1/fwd_rd2                read data with pending writes forwarded
//   busy                           queue non-empty or a write in flight
module wb_queue #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_wa,
  input  logic [DW-1:0] alu_wd,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_wa,
  input  logic [DW-1:0] mem_wd,
  output logic          mem_ready,
  output logic          regwrite,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic [DW-1:0] fwd_rd1,
  output logic [DW-1:0] fwd_rd2,
  output logic          busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Queue storage; only entries inside [head, head+count) are meaningful.
  logic [AW-1:0] q_wa [DEPTH];
  logic [DW-1:0] q_wd [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] free;
  logic          mem_acc, alu_acc, mem_push, alu_push, pop;
  logic [PW-1:0] mem_idx, alu_idx;

  // Circular index arithmetic that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [CW-1:0] off);
    int s;
    s = int'(base) + int'(off);
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Readiness looks only at the registered count: the pop happening this
  // cycle is not credited, which keeps ready off the drain path.
  always_comb begin
    free      = DEPTH_C - count_reg;
    mem_ready = (free != '0);
    alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);
  end

  always_comb begin
    mem_acc  = mem_valid && mem_ready;
    alu_acc  = alu_valid && alu_ready;
    // Writes to register 0 complete the handshake but are dropped here.
    mem_push = mem_acc && (mem_wa != '0);
    alu_push = alu_acc && (alu_wa != '0);
    pop      = (count_reg != '0);
    // mem is older than alu when both land in the same cycle.
    mem_idx  = wrap_add(head_reg, count_reg);
    alu_idx  = wrap_add(head_reg, count_reg + CW'(mem_push));
    head_next  = pop ? wrap_add(head_reg, CW'(1)) : head_reg;
    count_next = count_reg + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (mem_push) begin
      q_wa[mem_idx] <= mem_wa;
      q_wd[mem_idx] <= mem_wd;
    end
    if (alu_push) begin
      q_wa[alu_idx] <= alu_wa;
      q_wd[alu_idx] <= alu_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      count_reg <= '0;
      regwrite  <= 1'b0;
      wa        <= '0;
      wd        <= '0;
    end else begin
      head_reg  <= head_next;
      count_reg <= count_next;
      regwrite  <= pop;
      if (pop) begin
        wa <= q_wa[head_reg];
        wd <= q_wd[head_reg];
      end
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins, with the
  // in-flight output register and the raw file data as fallbacks.
  function automatic logic [DW-1:0] fwd_lookup(input logic [AW-1:0] ra,
                                               input logic [DW-1:0] rf);
    logic [DW-1:0] val;
    logic [PW-1:0] idx;
    val = rf;
    if (regwrite && (wa == ra)) val = wd;
    for (int k = 0; k < DEPTH; k++) begin
      idx = wrap_add(head_reg, CW'(k));
      if ((CW'(k) < count_reg) && (q_wa[idx] == ra)) val = q_wd[idx];
    end
    if (ra == '0) val = '0;
    return val;
  endfunction

  always_comb begin
    fwd_rd1 = fwd_lookup(ra1, rf_rd1);
    fwd_rd2 = fwd_lookup(ra2, rf_rd2);
  end

  assign busy = (count_reg != '0) || regwrite;

endmodule
